// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encodings and stream framing constants.
package inst_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_LO = 3'd1,
        LD_LEN_HI = 3'd2,
        LD_DATA   = 3'd3,
        LD_CSUM   = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } ld_state_e;

    // Total stream length in bytes for n words, excluding the optional checksum byte.
    function automatic int stream_bytes(input int n_words);
        return HDR_BYTES + BYTES_PER_WORD * n_words;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, grouped for reuse.
interface inst_loader_if;

    // Byte transfer: a byte moves only in a cycle where byte_valid_i && byte_ready_o.
    // The source may stall at any point; byte_i is meaningful only while byte_valid_i is high.
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;

    modport master (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o
    );

    modport slave (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o
    );

endinterface

// File: rtl/inst_loader_word_packer.sv
// Packs accepted little-endian bytes into 32-bit words; emits a one-cycle pulse with each full word.
module word_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] asm_q;
    logic        word_done_q;
    logic [31:0] word_q;

    assign last_byte_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_done_o = word_done_q;
    assign word_o      = word_q;

    // Bytes shift in from the top, so the first byte ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            word_done_q <= 1'b0;
            word_q      <= '0;
        end else begin
            word_done_q <= 1'b0;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (byte_en_i) begin
                if (last_byte_o) begin
                    cnt_q       <= '0;
                    word_q      <= {byte_i, asm_q};
                    word_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                    asm_q <= {byte_i, asm_q[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the core in reset.
// Optional trailing checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start_i,
    inst_loader_if.master      bus,
    output logic               core_hold_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output ld_state_e          state_o
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
`ifdef INST_LOADER_CHECKSUM_EN
    localparam ld_state_e END_ST = LD_CSUM;
`else
    localparam ld_state_e END_ST = LD_DONE;
`endif

    ld_state_e   state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        byte_acc;
    logic        start_load;
    logic        pk_en;
    logic        pk_last;
    logic        pk_done;
    logic [31:0] pk_word;
    logic [15:0] hdr_n;

    assign bus.byte_ready_o = state_q inside {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_CSUM};
    assign byte_acc   = bus.byte_valid_i && bus.byte_ready_o;
    assign start_load = load_start_i && (state_q inside {LD_IDLE, LD_DONE, LD_ERR});
    assign pk_en      = byte_acc && (state_q == LD_DATA);
    assign hdr_n      = {bus.byte_i, len_lo_q};

    word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start_load),
        .byte_en_i   (pk_en),
        .byte_i      (bus.byte_i),
        .last_byte_o (pk_last),
        .word_done_o (pk_done),
        .word_o      (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        next_addr_d = next_addr_q;
        mem_addr_d  = mem_addr_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        // Address is latched alongside the word so both appear with the strobe.
        if (pk_en && pk_last) begin
            mem_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + 32'd4;
            word_cnt_d  = word_cnt_q + 16'd1;
        end
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (load_start_i) begin
                    state_d     = LD_LEN_LO;
                    next_addr_d = ADDR_BASE;
                    word_cnt_d  = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            LD_LEN_LO: begin
                if (byte_acc) begin
                    len_lo_d = bus.byte_i;
                    state_d  = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (byte_acc) begin
                    n_d = hdr_n;
                    if ({1'b0, hdr_n} > MAX_W) state_d = LD_ERR;
                    else if (hdr_n == 16'd0)   state_d = END_ST;
                    else                       state_d = LD_DATA;
                end
            end
            LD_DATA: begin
                if (byte_acc) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d = csum_q + bus.byte_i;
`endif
                    if (pk_last && (word_cnt_q == n_q - 16'd1)) state_d = END_ST;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (byte_acc) state_d = (bus.byte_i == csum_q) ? LD_DONE : LD_ERR;
            end
`endif
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LD_IDLE;
            len_lo_q    <= '0;
            n_q         <= '0;
            word_cnt_q  <= '0;
            next_addr_q <= '0;
            mem_addr_q  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            next_addr_q <= next_addr_d;
            mem_addr_q  <= mem_addr_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.mem_we_o    = pk_done;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = pk_word;
    assign busy_o          = state_q inside {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_CSUM};
    assign core_hold_o     = busy_o || (state_q == LD_ERR);
    assign done_o          = (state_q == LD_DONE);
    assign err_o           = (state_q == LD_ERR);
    assign state_o         = state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: reset, normal load, stalls, limits, checksum and abort.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      load_start;
    logic      core_hold, busy, done, err;
    ld_state_e state;

    inst_loader_if bus();

    inst_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(4096)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start_i (load_start),
        .bus          (bus.master),
        .core_hold_o  (core_hold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .state_o      (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic        prev_we = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            check("we_one_cycle", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 1'b1, 1'b0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr_o, e[63:32]);
                check("wr_data", bus.mem_wdata_o, e[31:0]);
            end
        end
        prev_we = bus.mem_we_o;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Returns #1 after the edge at which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        n = 0;
        if (gaps) begin
            bus.byte_valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        while (!bus.byte_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!bus.byte_ready_o) check("ready_timeout", 1'b0, 1'b1);
        tick();
        bus.byte_valid_i = 1'b0;
    endtask

    logic [7:0] prog [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    task automatic send_prog(input bit gaps);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        start_load();
        check("start_busy_hold", {busy, core_hold}, 2'b11);
        for (int i = 0; i < 10; i++) begin
            send_byte(prog[i], gaps);
            if (i < 9) check("hold_during_load", core_hold, 1'b1);
        end
`ifdef INST_LOADER_CHECKSUM_EN
        check("csum_with_last_we", {bus.mem_we_o, state}, {1'b1, LD_CSUM});
        send_byte(8'hB6, gaps);
        check("done_after_csum", {done, err, busy, core_hold}, 4'b1000);
`else
        check("done_with_last_we", {bus.mem_we_o, done, busy, core_hold}, 4'b1100);
`endif
        repeat (3) tick();
        check("wr_hold_values", {bus.mem_addr_o, bus.mem_wdata_o}, {32'h0000_0004, 32'h0010_0093});
        check("all_written", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b1;
        load_start       = 1'b0;
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'hA5;
        repeat (2) tick();
        rst = 1'b0;

        // Idle after reset with byte_valid_i held high.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_bus", {bus.mem_addr_o, bus.mem_wdata_o}, 64'h0);
            check("idle_ctl", {bus.mem_we_o, core_hold, busy, done, err, bus.byte_ready_o}, 6'b0);
        end
        bus.byte_valid_i = 1'b0;

        send_prog(1'b0);
        send_prog(1'b1);

        // Zero-length load writes nothing.
        start_load();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
        check("n0_csum_state", state, LD_CSUM);
        send_byte(8'h00, 1'b0);
`endif
        check("n0_done", {done, err, busy, core_hold}, 4'b1000);

        // Over-limit header count.
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        check("ovf_err", {err, done, busy, core_hold, bus.mem_we_o}, 5'b10010);
        repeat (4) tick();
        check("ovf_hold_stays", {core_hold, err}, 2'b11);

        // Exactly MAX_WORDS is accepted; abort it with reset.
        start_load();
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        check("n4096_state", state, LD_DATA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("n4096_rst_ctl", {core_hold, busy, done, err}, 4'b0);

`ifdef INST_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({32'h0000_0000, 32'h0000_0013});
            start_load();
            send_byte(8'h01, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h13, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h00, 1'b0);
            check("csum_we", {bus.mem_we_o, state}, {1'b1, LD_CSUM});
            send_byte((k == 0) ? 8'h13 : 8'h14, 1'b0);
            if (k == 0) check("csum_match", {done, err, core_hold}, 3'b100);
            else        check("csum_mismatch", {done, err, core_hold}, 3'b011);
            tick();
            check("csum_written", exp_q.size(), 0);
        end
`endif

        // Reset after the 6th byte of a two-word load.
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        start_load();
        for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
        check("abort_first_we", bus.mem_we_o, 1'b1);
        rst              = 1'b1;
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'h93;
        tick();
        check("abort_bus", {bus.mem_addr_o, bus.mem_wdata_o}, 64'h0);
        check("abort_ctl", {bus.mem_we_o, core_hold, busy, done, err, bus.byte_ready_o}, 6'b0);
        rst = 1'b0;
        repeat (8) tick();
        bus.byte_valid_i = 1'b0;
        check("abort_state", state, LD_IDLE);
        check("abort_no_second", exp_q.size(), 0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
